app_mem_responder: RTL and testbench

//  Synthesizable responder for the DDR3 controller application (UI) interface. It accepts
//  app_en/app_cmd/app_wdf_* from the processor's memory state machine and answers with
//  app_rdy, app_wdf_rdy, read data and init_calib_complete, backed by on-chip block RAM.
//  It replaces ExternalMemory in simulation and in FPGA bring-up builds with no DDR3 fitted.

---
 rtl/ext_mem_pkg.sv | 14 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/app_mem_responder.sv | 157 +++++++++++++++
 tb/tb_app_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared definitions for the DDR3 application (UI) interface, used by the
// processor memory state machine and by the block-RAM responder.
package ext_mem_pkg;

  localparam int APP_DATA_WIDTH = 128;
  localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [APP_DATA_WIDTH-1:0] app_data_t;
  typedef logic [APP_MASK_WIDTH-1:0] app_mask_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags; DEPTH must be a power of 2 (>=2).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/app_mem_responder.sv
// Block-RAM stand-in for a DDR3 controller UI port: calibration delay, one pending
// write slot fed by a write-data FIFO, and a fixed-latency in-order read pipe.
module app_mem_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = ext_mem_pkg::APP_DATA_WIDTH,
  parameter int DEPTH_LOG2     = 10,
  parameter int CALIB_CYCLES   = 64,
  parameter int RD_LATENCY     = 4,
  parameter int WDF_DEPTH      = 4,
  parameter int STALL_PERIOD   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        init_calib_complete
);

  import ext_mem_pkg::*;

  localparam int MASK_W = APP_DATA_WIDTH / 8;
  localparam int FIFO_W = APP_DATA_WIDTH + MASK_W;
  localparam int ROWS   = 1 << DEPTH_LOG2;
  localparam int CW     = $clog2(CALIB_CYCLES + 1);
  localparam logic [CW-1:0] CALIB_LOAD = CW'(CALIB_CYCLES);
  localparam logic [CW-1:0] CALIB_ONE  = CW'(1);

  logic [APP_DATA_WIDTH-1:0] r_mem [ROWS];
  logic [CW-1:0]             r_calib_cnt;
  logic                      r_calib;
  logic                      r_pend_wr;
  logic [DEPTH_LOG2-1:0]     r_pend_row;
  logic [RD_LATENCY-1:0]     r_rd_vld;
  logic [APP_DATA_WIDTH-1:0] r_rd_data [RD_LATENCY];

  logic                      w_stall;
  logic                      w_app_rdy;
  logic                      w_wdf_rdy;
  logic                      w_cmd_acc;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic                      w_push;
  logic                      w_retire;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [FIFO_W-1:0]         w_fifo_out;
  logic [APP_DATA_WIDTH-1:0] w_wr_data;
  logic [MASK_W-1:0]         w_wr_mask;
  logic [DEPTH_LOG2-1:0]     w_cmd_row;
  logic                      w_unused;

  // Column bits and rows beyond the RAM are deliberately dropped (accesses wrap).
  assign w_cmd_row = app_addr[DEPTH_LOG2+2:3];
  assign w_unused  = ^{app_wdf_end, app_addr[2:0], app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3]};

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SW = $clog2(STALL_PERIOD + 1);
      localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
      localparam logic [SW-1:0] STALL_ONE  = SW'(1);
      logic [SW-1:0] r_stall_cnt;

      always_ff @(posedge clk) begin
        if (reset)                         r_stall_cnt <= '0;
        else if (r_stall_cnt == STALL_LAST) r_stall_cnt <= '0;
        else                               r_stall_cnt <= r_stall_cnt + STALL_ONE;
      end
      assign w_stall = (r_stall_cnt == '0);
    end else begin : g_no_stall
      assign w_stall = 1'b0;
    end
  endgenerate

  assign w_app_rdy = r_calib & ~r_pend_wr & ~w_stall;
  assign w_wdf_rdy = r_calib & ~w_fifo_full;
  assign w_cmd_acc = app_en & w_app_rdy;
  assign w_wr_acc  = w_cmd_acc & (app_cmd == CMD_WRITE);
  assign w_rd_acc  = w_cmd_acc & (app_cmd == CMD_READ);
  assign w_push    = app_wdf_wren & w_wdf_rdy;
  assign w_retire  = r_pend_wr & ~w_fifo_empty;
  assign {w_wr_mask, w_wr_data} = w_fifo_out;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (WDF_DEPTH)
  ) u_wdf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({app_wdf_mask, app_wdf_data}),
    .i_pop   (w_retire),
    .o_data  (w_fifo_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Calibration flag rises on the cycle the counter lands on zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_calib_cnt <= CALIB_LOAD;
      r_calib     <= 1'b0;
    end else begin
      if (r_calib_cnt != '0) r_calib_cnt <= r_calib_cnt - CALIB_ONE;
      r_calib <= r_calib | (r_calib_cnt == CALIB_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_wr  <= 1'b0;
      r_pend_row <= '0;
    end else if (w_wr_acc) begin
      r_pend_wr  <= 1'b1;
      r_pend_row <= w_cmd_row;
    end else if (w_retire) begin
      r_pend_wr  <= 1'b0;
    end
  end

  // RAM has no reset so its contents survive a recalibration.
  always_ff @(posedge clk) begin
    if (w_retire && !reset) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!w_wr_mask[i]) r_mem[r_pend_row][i*8 +: 8] <= w_wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_rd_data[i] <= '0;
    end else begin
      r_rd_vld     <= {r_rd_vld[RD_LATENCY-2:0], w_rd_acc};
      r_rd_data[0] <= w_rd_acc ? r_mem[w_cmd_row] : '0;
      for (int i = 1; i < RD_LATENCY; i++) r_rd_data[i] <= r_rd_data[i-1];
    end
  end

  assign app_rdy             = w_app_rdy;
  assign app_wdf_rdy         = w_wdf_rdy;
  assign app_rd_data         = r_rd_data[RD_LATENCY-1];
  assign app_rd_data_valid   = r_rd_vld[RD_LATENCY-1];
  assign app_rd_data_end     = r_rd_vld[RD_LATENCY-1];
  assign init_calib_complete = r_calib;

endmodule

// File: tb/tb_app_mem_responder.sv
// Directed bench for app_mem_responder: calibration, write/read paths, masks,
// FIFO full, back-to-back reads and reset during a read.
module tb_app_mem_responder;
  import ext_mem_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] rd_q[$];
  int           rd_cyc_q[$];

  app_mem_responder dut (
    .clk                 (clk),
    .reset               (reset),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every returned beat with the cycle it appeared on.
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      rd_q.push_back(app_rd_data);
      rd_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    app_en = 1'b0; app_cmd = 3'b000; app_addr = 28'h0;
    app_wdf_wren = 1'b0; app_wdf_data = 128'h0; app_wdf_mask = 16'h0; app_wdf_end = 1'b1;
  endtask

  // Drives a write command and/or a data beat until each is accepted. Entered and left at posedge+1.
  task automatic write_op(input logic [27:0] addr, input logic [127:0] data,
                          input logic [15:0] mask, input bit with_cmd, input bit with_data);
    bit cdone, ddone, cacc, dacc;
    int guard;
    cdone = !with_cmd;
    ddone = !with_data;
    if (with_cmd)  begin app_en = 1'b1; app_cmd = CMD_WRITE; app_addr = addr; end
    if (with_data) begin app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_mask = mask; end
    guard = 0;
    while (!(cdone && ddone) && guard < 100) begin
      @(negedge clk);
      cacc = app_en & app_rdy;
      dacc = app_wdf_wren & app_wdf_rdy;
      @(posedge clk); #1;
      if (cacc) begin cdone = 1'b1; app_en = 1'b0; end
      if (dacc) begin ddone = 1'b1; app_wdf_wren = 1'b0; end
      guard++;
    end
    if (!(cdone && ddone)) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr %h not accepted within 100 cycles", addr);
    end
    app_en = 1'b0; app_wdf_wren = 1'b0;
  endtask

  // Issues one read; returns negedges spent waiting for app_rdy and latency after accept (0 = none).
  task automatic read_op(input logic [27:0] addr, output int waits, output int lat,
                         output logic [127:0] data, output logic dend);
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = addr;
    waits = 0;
    @(negedge clk);
    while (!app_rdy && waits < 100) begin waits++; @(negedge clk); end
    @(posedge clk); #1;
    app_en = 1'b0;
    lat = 0; data = 128'h0; dend = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (app_rd_data_valid) begin lat = i; data = app_rd_data; dend = app_rd_data_end; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete} !== 5'b0 ||
        app_rd_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wdf=%b vld=%b end=%b cal=%b data=%h expected all 0",
               app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete, app_rd_data);
    end
  endtask

  task automatic test_calib();
    int n, early;
    app_en = 1'b1; app_cmd = 3'b010;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0; early = 0;
    @(negedge clk);
    while (!init_calib_complete && n < 200) begin
      if (app_rdy || app_wdf_rdy) early++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL calib_cycles: got %0d expected 64", n); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL rdy_before_calib: got %0d cycles expected 0", early); end
    checks++;
    if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
      errors++; $display("FAIL rdy_with_calib: got rdy=%b wdf=%b expected 1 1", app_rdy, app_wdf_rdy);
    end
    @(posedge clk); #1;
    app_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_q.size() !== 0) begin errors++; $display("FAIL invalid_cmd_no_read: got %0d beats expected 0", rd_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w, l; logic [127:0] d; logic e;
    write_op(28'h10, 128'hcafecafe_faceface_babebabe_beadbead, 16'h0, 1'b1, 1'b1);
    read_op(28'h10, w, l, d, e);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL wr_rd_wait: got %0d expected 1", w); end
    checks++;
    if (l !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", l); end
    checks++;
    if (d !== 128'hcafecafe_faceface_babebabe_beadbead) begin
      errors++; $display("FAIL rd_data: got %h expected cafecafefacefacebabebabebeadbead", d);
    end
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL rd_end: got %b expected 1", e); end
    @(negedge clk);
    checks++;
    if (app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b expected 0", app_rd_data_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_late_data();
    int w, l; logic [127:0] d; logic e; logic wr_ok;
    write_op(28'h20, 128'h0, 16'h0, 1'b1, 1'b0);
    fork
      read_op(28'h20, w, l, d, e);
      begin
        @(posedge clk); #1;
        app_wdf_wren = 1'b1; app_wdf_data = 128'h01234567_89abcdef_fedcba98_76543210; app_wdf_mask = 16'h0;
        @(negedge clk);
        wr_ok = app_wdf_rdy;
        @(posedge clk); #1;
        app_wdf_wren = 1'b0;
      end
    join
    checks++;
    if (wr_ok !== 1'b1) begin errors++; $display("FAIL late_wdf_rdy: got %b expected 1", wr_ok); end
    checks++;
    if (w !== 3) begin errors++; $display("FAIL late_rdy_wait: got %0d expected 3", w); end
    checks++;
    if (l !== 4 || d !== 128'h01234567_89abcdef_fedcba98_76543210) begin
      errors++; $display("FAIL late_raw_data: got lat=%0d data=%h expected lat=4 data=0123456789abcdeffedcba9876543210", l, d);
    end
  endtask

  task automatic test_mask();
    int w, l; logic [127:0] d; logic e;
    write_op(28'h30, 128'h0, 16'h0, 1'b1, 1'b1);
    write_op(28'h30, {128{1'b1}}, 16'h00FF, 1'b1, 1'b1);
    read_op(28'h30, w, l, d, e);
    checks++;
    if (l !== 4 || d !== 128'hFFFFFFFF_FFFFFFFF_00000000_00000000) begin
      errors++; $display("FAIL mask_merge: got lat=%0d data=%h expected lat=4 data=ffffffffffffffff0000000000000000", l, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pat [4];
    logic full_rdy;
    int g, gaps;
    for (int i = 0; i < 4; i++) pat[i] = {4{32'hA5A50000 + 32'(i)}};
    for (int i = 0; i < 4; i++) write_op(28'h0, pat[i], 16'h0, 1'b0, 1'b1);
    app_wdf_wren = 1'b1; app_wdf_data = {128{1'b1}}; app_wdf_mask = 16'h0;
    @(negedge clk);
    full_rdy = app_wdf_rdy;
    @(posedge clk); #1;
    app_wdf_wren = 1'b0;
    checks++;
    if (full_rdy !== 1'b0) begin errors++; $display("FAIL fifo_full_rdy: got %b expected 0", full_rdy); end
    for (int i = 0; i < 4; i++) write_op(28'(i * 8), 128'h0, 16'h0, 1'b1, 1'b0);
    rd_q.delete(); rd_cyc_q.delete();
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = 28'h0;
    g = 0; gaps = 0;
    @(negedge clk);
    while (!app_rdy && g < 50) begin g++; @(negedge clk); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      app_addr = 28'(i * 8);
      if (!app_rdy) gaps++;
      @(posedge clk); #1;
    end
    app_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL b2b_accept_gaps: got %0d expected 0", gaps); end
    checks++;
    if (rd_q.size() !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d expected 4", rd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_q[i] !== pat[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, rd_q[i], pat[i]); end
      end
      checks++;
      if (rd_cyc_q[3] - rd_cyc_q[0] !== 3 || rd_cyc_q[1] - rd_cyc_q[0] !== 1) begin
        errors++; $display("FAIL b2b_consecutive: got cycles %0d %0d %0d %0d expected consecutive",
                           rd_cyc_q[0], rd_cyc_q[1], rd_cyc_q[2], rd_cyc_q[3]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int w, l, n, g; logic [127:0] d; logic e;
    rd_q.delete();
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = 28'h8;
    g = 0;
    @(negedge clk);
    while (!app_rdy && g < 50) begin g++; @(negedge clk); end
    @(posedge clk); #1;
    app_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    @(negedge clk);
    checks++;
    if (app_rdy !== 1'b0 || init_calib_complete !== 1'b0) begin
      errors++; $display("FAIL recal_start: got rdy=%b cal=%b expected 0 0", app_rdy, init_calib_complete);
    end
    while (!init_calib_complete && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL recal_cycles: got %0d expected 64", n); end
    checks++;
    if (rd_q.size() !== 0) begin errors++; $display("FAIL reset_kills_read: got %0d beats expected 0", rd_q.size()); end
    @(posedge clk); #1;
    read_op(28'h2000, w, l, d, e);
    checks++;
    if (l !== 4 || d !== {4{32'hA5A50000}}) begin
      errors++; $display("FAIL alias_0x2000: got lat=%0d data=%h expected lat=4 data=%h", l, d, {4{32'hA5A50000}});
    end
    read_op(28'h18, w, l, d, e);
    checks++;
    if (l !== 4 || d !== {4{32'hA5A50003}}) begin
      errors++; $display("FAIL ram_kept: got lat=%0d data=%h expected lat=4 data=%h", l, d, {4{32'hA5A50003}});
    end
  endtask

  initial begin
    test_reset();
    test_calib();
    test_write_read();
    test_late_data();
    test_mask();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
